// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between two requesters and the mux2 round-robin arbiter.
// The optional lock input exists only when MUX2_ARB_LOCK_EN is defined.
interface mux2_rr_arbiter_if;
    logic req0;
    logic req1;
    logic done;
`ifdef MUX2_ARB_LOCK_EN
    logic lock;
`endif
    logic gnt0;
    logic gnt1;
    logic select;
    logic busy;
    logic timeout;

`ifdef MUX2_ARB_LOCK_EN
    modport master (output req0, req1, done, lock,
                    input  gnt0, gnt1, select, busy, timeout);
    modport slave  (input  req0, req1, done, lock,
                    output gnt0, gnt1, select, busy, timeout);
`else
    modport master (output req0, req1, done,
                    input  gnt0, gnt1, select, busy, timeout);
    modport slave  (input  req0, req1, done,
                    output gnt0, gnt1, select, busy, timeout);
`endif
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Two-source round-robin arbiter driving the select of a downstream 2:1 mux.
// Optional MUX2_ARB_LOCK_EN adds a lock input that suspends the hold limit.
module mux2_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CW       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mux2_rr_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    localparam logic [CW-1:0] HoldLast = CW'(MAX_HOLD - 1);

    state_e          r_state, w_state_d;
    logic            r_last, w_last_d;
    logic [CW-1:0]   r_hold_cnt, w_hold_cnt_d;
    logic            r_gnt0, r_gnt1, r_select, r_busy, r_timeout;
    logic            w_gnt0_d, w_gnt1_d, w_select_d, w_busy_d, w_timeout_d;

    logic            w_lock;
    logic            w_in_own;
    logic            w_own1;
    logic            w_own_req;
    logic            w_oth_req;
    logic            w_limit_hit;
    logic            w_release;

`ifdef MUX2_ARB_LOCK_EN
    assign w_lock = bus.lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_in_own    = (r_state != StIdle);
    assign w_own1      = (r_state == StOwn1);
    assign w_own_req   = w_own1 ? bus.req1 : bus.req0;
    assign w_oth_req   = w_own1 ? bus.req0 : bus.req1;
    assign w_limit_hit = (r_hold_cnt == HoldLast) && !w_lock;
    assign w_release   = bus.done || !w_own_req || w_limit_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_last     <= 1'b1;
            r_hold_cnt <= '0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_select   <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_last     <= w_last_d;
            r_hold_cnt <= w_hold_cnt_d;
            r_gnt0     <= w_gnt0_d;
            r_gnt1     <= w_gnt1_d;
            r_select   <= w_select_d;
            r_busy     <= w_busy_d;
            r_timeout  <= w_timeout_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_last_d     = r_last;
        w_hold_cnt_d = r_hold_cnt;
        unique case (r_state)
            StIdle: begin
                // r_last == 1 means source 1 went last, so source 0 wins a tie
                if (bus.req0 && (!bus.req1 || r_last)) begin
                    w_state_d = StOwn0;
                end else if (bus.req1) begin
                    w_state_d = StOwn1;
                end
            end
            StOwn0, StOwn1: begin
                if (w_release) begin
                    w_last_d  = w_own1;
                    w_state_d = !w_oth_req ? StIdle : (w_own1 ? StOwn0 : StOwn1);
                end
            end
            default: w_state_d = StIdle;
        endcase

        // Cleared on every new grant or return to idle; frozen by lock; saturating.
        if (w_state_d == StIdle || w_state_d != r_state) begin
            w_hold_cnt_d = '0;
        end else if (!w_lock && r_hold_cnt != '1) begin
            w_hold_cnt_d = r_hold_cnt + CW'(1);
        end
    end

    always_comb begin
        w_gnt0_d    = (w_state_d == StOwn0);
        w_gnt1_d    = (w_state_d == StOwn1);
        w_busy_d    = (w_state_d != StIdle);
        w_select_d  = w_gnt1_d ? 1'b1 : (w_gnt0_d ? 1'b0 : r_select);
        w_timeout_d = w_in_own && w_limit_hit && !bus.done && w_own_req;
    end

    assign bus.gnt0    = r_gnt0;
    assign bus.gnt1    = r_gnt1;
    assign bus.select  = r_select;
    assign bus.busy    = r_busy;
    assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed self-checking bench for mux2_rr_arbiter (MAX_HOLD=8).
// Lock scenario runs only when MUX2_ARB_LOCK_EN is defined.
module tb_mux2_rr_arbiter;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mux2_rr_arbiter_if u_if ();

    mux2_rr_arbiter #(
        .MAX_HOLD (8),
        .CW       (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic g0, input logic g1,
                              input logic sel, input logic bsy, input logic to);
        check({tag, ".gnt0"},    u_if.gnt0,    g0);
        check({tag, ".gnt1"},    u_if.gnt1,    g1);
        check({tag, ".select"},  u_if.select,  sel);
        check({tag, ".busy"},    u_if.busy,    bsy);
        check({tag, ".timeout"}, u_if.timeout, to);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Invariants sampled on the inactive edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("inv_mutex", u_if.gnt0 & u_if.gnt1, 1'b0);
            if (u_if.gnt1 === 1'b1) check("inv_sel1", u_if.select, 1'b1);
            if (u_if.gnt0 === 1'b1) check("inv_sel0", u_if.select, 1'b0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp1;
        errors = 0;
        checks = 0;
        rst_n     = 1'b0;
        u_if.req0 = 1'b1;
        u_if.req1 = 1'b1;
        u_if.done = 1'b0;
`ifdef MUX2_ARB_LOCK_EN
        u_if.lock = 1'b0;
`endif
        #2;
        expect_out("reset_async", 0, 0, 0, 0, 0);
        tick;
        expect_out("reset_edge", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Tie after reset: source 0 first; then hold limit with handover to 1
        tick;
        expect_out("first_grant", 1, 0, 0, 1, 0);
        for (int i = 1; i < 8; i++) begin
            tick;
            expect_out($sformatf("hold0_c%0d", i), 1, 0, 0, 1, 0);
        end
        tick;
        expect_out("timeout_handover", 0, 1, 1, 1, 1);
        tick;
        expect_out("timeout_pulse_end", 0, 1, 1, 1, 0);

        u_if.done = 1'b1;
        tick;
        expect_out("done_handover", 1, 0, 0, 1, 0);
        u_if.done = 1'b0;

        // Fairness: done every third cycle alternates owners without dropping busy
        exp1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            expect_out($sformatf("fair%0d_a", k), ~exp1, exp1, exp1, 1, 0);
            tick;
            expect_out($sformatf("fair%0d_b", k), ~exp1, exp1, exp1, 1, 0);
            u_if.done = 1'b1;
            tick;
            exp1 = ~exp1;
            expect_out($sformatf("fair%0d_sw", k), ~exp1, exp1, exp1, 1, 0);
            u_if.done = 1'b0;
        end

        // done coinciding with the hold limit: plain release, no pulse
        for (int i = 0; i < 7; i++) tick;
        expect_out("pre_limit", 1, 0, 0, 1, 0);
        u_if.done = 1'b1;
        tick;
        expect_out("done_at_limit", 0, 1, 1, 1, 0);
        u_if.done = 1'b0;

        // Owner drops request, nobody waiting: idle, select stays 1
        u_if.req0 = 1'b0;
        u_if.req1 = 1'b0;
        tick;
        expect_out("drop_to_idle", 0, 0, 1, 0, 0);
        u_if.done = 1'b1;
        tick;
        expect_out("idle_done_ignored", 0, 0, 1, 0, 0);
        u_if.done = 1'b0;

        u_if.req1 = 1'b1;
        tick;
        expect_out("single_req1", 0, 1, 1, 1, 0);
        u_if.req1 = 1'b0;
        tick;
        expect_out("req1_release", 0, 0, 1, 0, 0);
        u_if.req0 = 1'b1;
        tick;
        expect_out("single_req0", 1, 0, 0, 1, 0);

        // Hold limit with no other requester: idle + pulse, then regrant
        for (int i = 1; i < 8; i++) tick;
        expect_out("solo_hold_end", 1, 0, 0, 1, 0);
        tick;
        expect_out("solo_timeout", 0, 0, 0, 0, 1);
        tick;
        expect_out("solo_regrant", 1, 0, 0, 1, 0);

        // Tie with last=0 goes to source 1
        u_if.req0 = 1'b0;
        tick;
        expect_out("idle_last0", 0, 0, 0, 0, 0);
        u_if.req0 = 1'b1;
        u_if.req1 = 1'b1;
        tick;
        expect_out("tie_last0", 0, 1, 1, 1, 0);

        // Asynchronous reset between edges while OWN1
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_mid_grant", 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        tick;
        expect_out("post_reset_tie", 1, 0, 0, 1, 0);

`ifdef MUX2_ARB_LOCK_EN
        u_if.lock = 1'b1;
        for (int i = 1; i < 20; i++) begin
            tick;
            expect_out($sformatf("lock_c%0d", i), 1, 0, 0, 1, 0);
        end
        u_if.done = 1'b1;
        tick;
        expect_out("lock_done", 0, 1, 1, 1, 0);
        u_if.done = 1'b0;
        u_if.lock = 1'b0;
`endif

        tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
